// File: rtl/axil_slave_ram.sv
// -----------------------------------------------------------------------------
// axil_slave_ram
//
// AXI4-Lite slave that exposes a small word-organised RAM. The write and read
// channels are completely independent, so a read can complete while a write is
// being assembled.
//
// Write channel
//   AW and W may be accepted in either order, or in the same cycle. Whichever
//   arrives first is parked in a holding register. The memory is updated on the
//   edge where both halves are available, and B is raised at that same edge.
//   While B is outstanding, both AWREADY and WREADY are held low, so at most one
//   write is in flight.
//
// Read channel
//   An AR handshake reads the memory and loads RDATA/RRESP. RVALID is raised on
//   the next cycle. ARREADY stays low until the R handshake.
//
// Address decode
//   The word index is taken from the bits just above the byte offset, and the
//   byte offset itself is ignored. Any address at or beyond the end of the
//   memory is rejected with SLVERR: a write to it is dropped and a read from it
//   returns zero data.
//
// Ports
//   ACLK           clock, all logic on the rising edge
//   ARESET         asynchronous reset, active low
//   i_AWADDR       write byte address          i_AWVALID / o_AWREADY
//   i_WDATA        write data                  i_WSTRB   byte-lane enables
//   i_WVALID       write data valid            o_WREADY
//   o_BRESP        write response              o_BVALID  / i_BREADY
//   i_ARADDR       read byte address           i_ARVALID / o_ARREADY
//   o_RDATA        read data                   o_RRESP   read response
//   o_RVALID       read data valid             i_RREADY
// -----------------------------------------------------------------------------
module axil_slave_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 16
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   i_AWADDR,
  input  logic                i_AWVALID,
  output logic                o_AWREADY,
  input  logic [DATA_W-1:0]   i_WDATA,
  input  logic [DATA_W/8-1:0] i_WSTRB,
  input  logic                i_WVALID,
  output logic                o_WREADY,
  output logic [1:0]          o_BRESP,
  output logic                o_BVALID,
  input  logic                i_BREADY,
  input  logic [ADDR_W-1:0]   i_ARADDR,
  input  logic                i_ARVALID,
  output logic                o_ARREADY,
  output logic [DATA_W-1:0]   o_RDATA,
  output logic [1:0]          o_RRESP,
  output logic                o_RVALID,
  input  logic                i_RREADY
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(DEPTH);

  // The size of the memory in bytes, held one bit wider than the address.
  // This keeps the range compare correct even when the memory fills the whole
  // address space.
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(DEPTH * STRB_W);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Elaboration-time parameter sanity checks
  if (DATA_W != 32 && DATA_W != 64) begin : g_badDataW
    $error("axil_slave_ram: DATA_W must be 32 or 64");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_badDepth
    $error("axil_slave_ram: DEPTH must be a power of two, at least 2");
  end
  if ((DEPTH * STRB_W) > (2 ** ADDR_W)) begin : g_badSize
    $error("axil_slave_ram: memory does not fit in the address space");
  end

  function automatic logic f_inRange(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < MEM_BYTES);
  endfunction

  // ---------------------------------------------------------------------------
  // Storage (intentionally not reset)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  // WR_HAVE_ADDR and WR_HAVE_DATA act as the "address held" and "data held"
  // flags. WR_RESP means a B response is outstanding.
  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_ADDR,
    WR_HAVE_DATA,
    WR_RESP
  } wrState_t;

  wrState_t              r_wrState;
  wrState_t              w_wrNext;
  logic                  r_awReady;
  logic                  r_wReady;
  logic                  r_bValid;
  logic [1:0]            r_bResp;
  logic [ADDR_W-1:0]     r_awAddr;
  logic [DATA_W-1:0]     r_wData;
  logic [STRB_W-1:0]     r_wStrb;

  logic                  w_awHs;
  logic                  w_wHs;
  logic                  w_commit;
  logic [ADDR_W-1:0]     w_cmtAddr;
  logic [DATA_W-1:0]     w_cmtData;
  logic [STRB_W-1:0]     w_cmtStrb;
  logic                  w_cmtInRange;
  logic [IDX_W-1:0]      w_cmtIdx;

  assign w_awHs = i_AWVALID & r_awReady;
  assign w_wHs  = i_WVALID  & r_wReady;

  // A half that has already been parked comes from its holding register.
  // Otherwise it comes straight from the bus, in the cycle it is handshaking.
  assign w_cmtAddr    = (r_wrState == WR_HAVE_ADDR) ? r_awAddr : i_AWADDR;
  assign w_cmtData    = (r_wrState == WR_HAVE_DATA) ? r_wData  : i_WDATA;
  assign w_cmtStrb    = (r_wrState == WR_HAVE_DATA) ? r_wStrb  : i_WSTRB;
  assign w_cmtInRange = f_inRange(w_cmtAddr);
  assign w_cmtIdx     = w_cmtAddr[ADDR_LSB +: IDX_W];

  always_comb begin
    w_wrNext = r_wrState;
    w_commit = 1'b0;
    case (r_wrState)
      WR_IDLE: begin
        if (w_awHs && w_wHs) begin
          w_commit = 1'b1;
          w_wrNext = WR_RESP;
        end else if (w_awHs) begin
          w_wrNext = WR_HAVE_ADDR;
        end else if (w_wHs) begin
          w_wrNext = WR_HAVE_DATA;
        end
      end
      WR_HAVE_ADDR: begin
        if (w_wHs) begin
          w_commit = 1'b1;
          w_wrNext = WR_RESP;
        end
      end
      WR_HAVE_DATA: begin
        if (w_awHs) begin
          w_commit = 1'b1;
          w_wrNext = WR_RESP;
        end
      end
      WR_RESP: begin
        // BVALID is known to be high in this state, so BREADY alone completes
        // the B handshake.
        if (i_BREADY) begin
          w_wrNext = WR_IDLE;
        end
      end
      default: begin
        w_wrNext = WR_IDLE;
      end
    endcase
  end

  // The READY and VALID outputs are registered copies of the next state.
  // That way they drop to 0 during reset, and rise on the first edge after
  // reset is released.
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      r_wrState <= WR_IDLE;
      r_awReady <= 1'b0;
      r_wReady  <= 1'b0;
      r_bValid  <= 1'b0;
      r_bResp   <= RESP_OKAY;
      r_awAddr  <= '0;
      r_wData   <= '0;
      r_wStrb   <= '0;
    end else begin
      r_wrState <= w_wrNext;
      r_awReady <= (w_wrNext == WR_IDLE) || (w_wrNext == WR_HAVE_DATA);
      r_wReady  <= (w_wrNext == WR_IDLE) || (w_wrNext == WR_HAVE_ADDR);
      r_bValid  <= (w_wrNext == WR_RESP);
      if (w_awHs) begin
        r_awAddr <= i_AWADDR;
      end
      if (w_wHs) begin
        r_wData <= i_WDATA;
        r_wStrb <= i_WSTRB;
      end
      if (w_commit) begin
        r_bResp <= w_cmtInRange ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Byte-lane memory update. w_commit is derived from state that is cleared
  // asynchronously, so nothing is written while reset is asserted.
  always_ff @(posedge ACLK) begin
    if (w_commit && w_cmtInRange) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_cmtStrb[i]) begin
          r_mem[w_cmtIdx][8*i +: 8] <= w_cmtData[8*i +: 8];
        end
      end
    end
  end

  assign o_AWREADY = r_awReady;
  assign o_WREADY  = r_wReady;
  assign o_BVALID  = r_bValid;
  assign o_BRESP   = r_bResp;

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  typedef enum logic {
    RD_IDLE,
    RD_VALID
  } rdState_t;

  rdState_t              r_rdState;
  rdState_t              w_rdNext;
  logic                  r_arReady;
  logic                  r_rValid;
  logic [DATA_W-1:0]     r_rData;
  logic [1:0]            r_rResp;

  logic                  w_arHs;
  logic                  w_arInRange;
  logic [IDX_W-1:0]      w_arIdx;

  assign w_arHs      = i_ARVALID & r_arReady;
  assign w_arInRange = f_inRange(i_ARADDR);
  assign w_arIdx     = i_ARADDR[ADDR_LSB +: IDX_W];

  always_comb begin
    w_rdNext = r_rdState;
    case (r_rdState)
      RD_IDLE: begin
        if (w_arHs) begin
          w_rdNext = RD_VALID;
        end
      end
      RD_VALID: begin
        if (i_RREADY) begin
          w_rdNext = RD_IDLE;
        end
      end
      default: begin
        w_rdNext = RD_IDLE;
      end
    endcase
  end

  // The memory is sampled with its pre-edge contents. A write that commits to
  // the same word on the same edge is therefore not seen by this read.
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      r_rdState <= RD_IDLE;
      r_arReady <= 1'b0;
      r_rValid  <= 1'b0;
      r_rData   <= '0;
      r_rResp   <= RESP_OKAY;
    end else begin
      r_rdState <= w_rdNext;
      r_arReady <= (w_rdNext == RD_IDLE);
      r_rValid  <= (w_rdNext == RD_VALID);
      if (w_arHs) begin
        if (w_arInRange) begin
          r_rData <= r_mem[w_arIdx];
          r_rResp <= RESP_OKAY;
        end else begin
          r_rData <= '0;
          r_rResp <= RESP_SLVERR;
        end
      end
    end
  end

  assign o_ARREADY = r_arReady;
  assign o_RVALID  = r_rValid;
  assign o_RDATA   = r_rData;
  assign o_RRESP   = r_rResp;

endmodule

// File: tb/tb_axil_slave_ram.sv
// -----------------------------------------------------------------------------
// tb_axil_slave_ram
//
// Testbench for axil_slave_ram. It drives a 32-bit instance (the defaults) and
// a 64-bit instance; both share the clock and the reset.
//
// Single-beat transactions are stored as a table of vectors. Multi-cycle
// corner cases are written out as hand sequences: W before AW, back-pressure,
// a simultaneous read and write, a reset in the middle of a write, and 64-bit
// strobes.
//
// Expected responses are pushed to a queue when the stimulus is driven, and
// popped when the DUT presents B or R.
// -----------------------------------------------------------------------------
module tb_axil_slave_ram;

  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  // 32-bit DUT signals
  logic [11:0] awAddr;   logic awValid;  logic awReady;
  logic [31:0] wData;    logic [3:0] wStrb; logic wValid; logic wReady;
  logic [1:0]  bResp;    logic bValid;   logic bReady;
  logic [11:0] arAddr;   logic arValid;  logic arReady;
  logic [31:0] rData;    logic [1:0] rResp; logic rValid; logic rReady;

  // 64-bit DUT signals
  logic [11:0] awAddr64; logic awValid64; logic awReady64;
  logic [63:0] wData64;  logic [7:0] wStrb64; logic wValid64; logic wReady64;
  logic [1:0]  bResp64;  logic bValid64; logic bReady64;
  logic [11:0] arAddr64; logic arValid64; logic arReady64;
  logic [63:0] rData64;  logic [1:0] rResp64; logic rValid64; logic rReady64;

  axil_slave_ram #(.DATA_W(32), .ADDR_W(12), .DEPTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .i_AWADDR(awAddr), .i_AWVALID(awValid), .o_AWREADY(awReady),
    .i_WDATA(wData), .i_WSTRB(wStrb), .i_WVALID(wValid), .o_WREADY(wReady),
    .o_BRESP(bResp), .o_BVALID(bValid), .i_BREADY(bReady),
    .i_ARADDR(arAddr), .i_ARVALID(arValid), .o_ARREADY(arReady),
    .o_RDATA(rData), .o_RRESP(rResp), .o_RVALID(rValid), .i_RREADY(rReady)
  );

  axil_slave_ram #(.DATA_W(64), .ADDR_W(12), .DEPTH(16)) dut64 (
    .ACLK(ACLK), .ARESET(ARESET),
    .i_AWADDR(awAddr64), .i_AWVALID(awValid64), .o_AWREADY(awReady64),
    .i_WDATA(wData64), .i_WSTRB(wStrb64), .i_WVALID(wValid64), .o_WREADY(wReady64),
    .o_BRESP(bResp64), .o_BVALID(bValid64), .i_BREADY(bReady64),
    .i_ARADDR(arAddr64), .i_ARVALID(arValid64), .o_ARREADY(arReady64),
    .o_RDATA(rData64), .o_RRESP(rResp64), .o_RVALID(rValid64), .i_RREADY(rReady64)
  );

  typedef struct {
    logic [1:0]  resp;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    bit          isRead;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  exp_t bExp[$];
  exp_t rExp[$];
  int   errors = 0;
  int   checks = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic doWrite(input logic [11:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [1:0] resp);
    int n;
    exp_t e;
    @(negedge ACLK);
    n = 0;
    while (!(awReady && wReady) && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (!(awReady && wReady)) failNow("write_ready");
    awAddr = addr; awValid = 1'b1;
    wData = data; wStrb = strb; wValid = 1'b1;
    bExp.push_back('{resp, 64'h0});
    @(negedge ACLK);
    awValid = 1'b0; wValid = 1'b0;
    checkOutput($sformatf("bvalid_latency@%0h", addr), bValid, 1'b1);
    e = bExp.pop_front();
    checkOutput($sformatf("bresp@%0h", addr), bResp, e.resp);
    if (bReady) begin
      @(negedge ACLK);
      checkOutput($sformatf("bvalid_fall@%0h", addr), bValid, 1'b0);
    end
  endtask

  task automatic doRead(input logic [11:0] addr, input logic [31:0] data,
                        input logic [1:0] resp);
    int n;
    exp_t e;
    @(negedge ACLK);
    n = 0;
    while (!arReady && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (!arReady) failNow("read_ready");
    arAddr = addr; arValid = 1'b1;
    rExp.push_back('{resp, {32'h0, data}});
    @(negedge ACLK);
    arValid = 1'b0;
    checkOutput($sformatf("rvalid_latency@%0h", addr), rValid, 1'b1);
    e = rExp.pop_front();
    checkOutput($sformatf("rdata@%0h", addr), rData, e.data);
    checkOutput($sformatf("rresp@%0h", addr), rResp, e.resp);
    if (rReady) begin
      @(negedge ACLK);
      checkOutput($sformatf("rvalid_fall@%0h", addr), rValid, 1'b0);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.isRead) doRead(v.addr, v.rdata, v.resp);
    else          doWrite(v.addr, v.data, v.strb, v.resp);
  endtask

  task automatic doWrite64(input logic [11:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, input logic [1:0] resp);
    int n;
    exp_t e;
    @(negedge ACLK);
    n = 0;
    while (!(awReady64 && wReady64) && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (!(awReady64 && wReady64)) failNow("write64_ready");
    awAddr64 = addr; awValid64 = 1'b1;
    wData64 = data; wStrb64 = strb; wValid64 = 1'b1;
    bExp.push_back('{resp, 64'h0});
    @(negedge ACLK);
    awValid64 = 1'b0; wValid64 = 1'b0;
    checkOutput($sformatf("b64_valid@%0h", addr), bValid64, 1'b1);
    e = bExp.pop_front();
    checkOutput($sformatf("b64_resp@%0h", addr), bResp64, e.resp);
    @(negedge ACLK);
  endtask

  task automatic doRead64(input logic [11:0] addr, input logic [63:0] data,
                          input logic [1:0] resp);
    int n;
    exp_t e;
    @(negedge ACLK);
    n = 0;
    while (!arReady64 && n < 20) begin
      @(negedge ACLK);
      n++;
    end
    if (!arReady64) failNow("read64_ready");
    arAddr64 = addr; arValid64 = 1'b1;
    rExp.push_back('{resp, data});
    @(negedge ACLK);
    arValid64 = 1'b0;
    checkOutput($sformatf("r64_valid@%0h", addr), rValid64, 1'b1);
    e = rExp.pop_front();
    checkOutput($sformatf("r64_data@%0h", addr), rData64, e.data);
    checkOutput($sformatf("r64_resp@%0h", addr), rResp64, e.resp);
    @(negedge ACLK);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_awready"}, awReady, 1'b0);
    checkOutput({tag, "_wready"},  wReady,  1'b0);
    checkOutput({tag, "_arready"}, arReady, 1'b0);
    checkOutput({tag, "_bvalid"},  bValid,  1'b0);
    checkOutput({tag, "_rvalid"},  rValid,  1'b0);
    checkOutput({tag, "_bresp"},   bResp,   2'b00);
    checkOutput({tag, "_rresp"},   rResp,   2'b00);
    checkOutput({tag, "_rdata"},   rData,   32'h0);
  endtask

  // Watchdog: stops a hung run and still reports it
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[20];
    int   n;
    exp_t e;

    vecs[0]  = '{1'b0, 12'h004, 32'hA5A5_1234, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b1, 12'h004, 32'h0,         4'h0, 2'b00, 32'hA5A5_1234};
    vecs[2]  = '{1'b0, 12'h008, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
    vecs[3]  = '{1'b0, 12'h000, 32'h0000_0000, 4'hF, 2'b00, 32'h0};
    vecs[4]  = '{1'b0, 12'h000, 32'hDEAD_BEEF, 4'h3, 2'b00, 32'h0};
    vecs[5]  = '{1'b1, 12'h000, 32'h0,         4'h0, 2'b00, 32'h0000_BEEF};
    vecs[6]  = '{1'b0, 12'h003, 32'h1234_5678, 4'h8, 2'b00, 32'h0};
    vecs[7]  = '{1'b1, 12'h002, 32'h0,         4'h0, 2'b00, 32'h1200_BEEF};
    vecs[8]  = '{1'b0, 12'h000, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0};
    vecs[9]  = '{1'b1, 12'h000, 32'h0,         4'h0, 2'b00, 32'h1200_BEEF};
    vecs[10] = '{1'b0, 12'h040, 32'h5555_5555, 4'hF, 2'b10, 32'h0};
    vecs[11] = '{1'b1, 12'h040, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[12] = '{1'b0, 12'h03C, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
    vecs[13] = '{1'b1, 12'h03C, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
    vecs[14] = '{1'b1, 12'h000, 32'h0,         4'h0, 2'b00, 32'h1200_BEEF};
    vecs[15] = '{1'b0, 12'hFFC, 32'h1234_5678, 4'hF, 2'b10, 32'h0};
    vecs[16] = '{1'b1, 12'hFFC, 32'h0,         4'h0, 2'b10, 32'h0};
    vecs[17] = '{1'b0, 12'h00C, 32'h7777_7777, 4'hF, 2'b00, 32'h0};
    vecs[18] = '{1'b1, 12'h008, 32'h0,         4'h0, 2'b00, 32'hFFFF_FFFF};
    vecs[19] = '{1'b1, 12'h004, 32'h0,         4'h0, 2'b00, 32'hA5A5_1234};

    ARESET = 1'b0;
    awAddr = '0; awValid = 0; wData = '0; wStrb = '0; wValid = 0; bReady = 1;
    arAddr = '0; arValid = 0; rReady = 1;
    awAddr64 = '0; awValid64 = 0; wData64 = '0; wStrb64 = '0; wValid64 = 0; bReady64 = 1;
    arAddr64 = '0; arValid64 = 0; rReady64 = 1;

    // Reset state and release timing
    #1;
    checkAllZero("reset");
    repeat (3) @(negedge ACLK);
    ARESET = 1'b1;
    #1;
    checkOutput("awready_before_edge", awReady, 1'b0);
    @(negedge ACLK);
    checkOutput("awready_after_reset", awReady, 1'b1);
    checkOutput("wready_after_reset",  wReady,  1'b1);
    checkOutput("arready_after_reset", arReady, 1'b1);

    for (int i = 0; i < 20; i++) applyStimulus(vecs[i]);

    // W three cycles ahead of AW, with partial strobes over 0xFFFFFFFF
    @(negedge ACLK);
    n = 0;
    while (!wReady && n < 20) begin @(negedge ACLK); n++; end
    wData = 32'h1122_3344; wStrb = 4'b0101; wValid = 1'b1;
    @(negedge ACLK);
    wValid = 1'b0;
    checkOutput("wfirst_wready_held", wReady, 1'b0);
    checkOutput("wfirst_awready",     awReady, 1'b1);
    checkOutput("wfirst_bvalid_0",    bValid, 1'b0);
    @(negedge ACLK);
    checkOutput("wfirst_bvalid_1",    bValid, 1'b0);
    @(negedge ACLK);
    awAddr = 12'h008; awValid = 1'b1;
    bExp.push_back('{2'b00, 64'h0});
    @(negedge ACLK);
    awValid = 1'b0;
    checkOutput("wfirst_bvalid_latency", bValid, 1'b1);
    e = bExp.pop_front();
    checkOutput("wfirst_bresp", bResp, e.resp);
    @(negedge ACLK);
    checkOutput("wfirst_bvalid_fall", bValid, 1'b0);
    doRead(12'h008, 32'hFF22_FF44, 2'b00);

    // B back-pressure
    bReady = 1'b0;
    doWrite(12'h010, 32'h0F0F_0F0F, 4'hF, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      checkOutput($sformatf("bp_bvalid_%0d", i),  bValid,  1'b1);
      checkOutput($sformatf("bp_awready_%0d", i), awReady, 1'b0);
      checkOutput($sformatf("bp_wready_%0d", i),  wReady,  1'b0);
      checkOutput($sformatf("bp_bresp_%0d", i),   bResp,   2'b00);
    end
    bReady = 1'b1;
    @(negedge ACLK);
    checkOutput("bp_bvalid_fall", bValid,  1'b0);
    checkOutput("bp_awready_up",  awReady, 1'b1);
    checkOutput("bp_wready_up",   wReady,  1'b1);

    // R back-pressure
    rReady = 1'b0;
    doRead(12'h010, 32'h0F0F_0F0F, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      checkOutput($sformatf("rbp_rvalid_%0d", i),  rValid,  1'b1);
      checkOutput($sformatf("rbp_arready_%0d", i), arReady, 1'b0);
      checkOutput($sformatf("rbp_rdata_%0d", i),   rData,   32'h0F0F_0F0F);
    end
    rReady = 1'b1;
    @(negedge ACLK);
    checkOutput("rbp_rvalid_fall", rValid,  1'b0);
    checkOutput("rbp_arready_up",  arReady, 1'b1);

    // Read and write to the same word on the same edge: read sees old data
    @(negedge ACLK);
    n = 0;
    while (!(awReady && wReady && arReady) && n < 20) begin @(negedge ACLK); n++; end
    awAddr = 12'h004; awValid = 1'b1;
    wData = 32'h0101_0101; wStrb = 4'hF; wValid = 1'b1;
    arAddr = 12'h004; arValid = 1'b1;
    bExp.push_back('{2'b00, 64'h0});
    rExp.push_back('{2'b00, 64'hA5A5_1234});
    @(negedge ACLK);
    awValid = 1'b0; wValid = 1'b0; arValid = 1'b0;
    checkOutput("rw_bvalid", bValid, 1'b1);
    checkOutput("rw_rvalid", rValid, 1'b1);
    e = bExp.pop_front();
    checkOutput("rw_bresp", bResp, e.resp);
    e = rExp.pop_front();
    checkOutput("rw_rdata_old", rData, e.data);
    checkOutput("rw_rresp", rResp, e.resp);
    @(negedge ACLK);
    checkOutput("rw_bvalid_fall", bValid, 1'b0);
    checkOutput("rw_rvalid_fall", rValid, 1'b0);
    doRead(12'h004, 32'h0101_0101, 2'b00);

    // Reset after AW, before W: held address is discarded
    @(negedge ACLK);
    awAddr = 12'h00C; awValid = 1'b1;
    @(negedge ACLK);
    awValid = 1'b0;
    checkOutput("mid_awready_held", awReady, 1'b0);
    ARESET = 1'b0;
    #1;
    checkAllZero("midreset");
    repeat (2) @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    checkOutput("mid_awready_back", awReady, 1'b1);
    wData = 32'h0BAD_F00D; wStrb = 4'hF; wValid = 1'b1;
    @(negedge ACLK);
    wValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("mid_no_bvalid_%0d", i), bValid, 1'b0);
      @(negedge ACLK);
    end
    ARESET = 1'b0;
    @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    doRead(12'h00C, 32'h7777_7777, 2'b00);

    // 64-bit instance: upper-half strobes and range check
    doWrite64(12'h000, 64'h2222_2222_2222_2222, 8'hFF, 2'b00);
    doWrite64(12'h008, 64'h1111_1111_1111_1111, 8'hFF, 2'b00);
    doWrite64(12'h00C, 64'hAABB_CCDD_EEFF_0011, 8'hF0, 2'b00);
    doRead64(12'h008, 64'hAABB_CCDD_1111_1111, 2'b00);
    doRead64(12'h000, 64'h2222_2222_2222_2222, 2'b00);
    doWrite64(12'h080, 64'h3333_3333_3333_3333, 8'hFF, 2'b10);
    doRead64(12'h080, 64'h0, 2'b10);
    doRead64(12'h000, 64'h2222_2222_2222_2222, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
